wb_stage: RTL and testbench

Writeback stage of the 5-stage RV32I pipeline. It holds one retiring instruction in a single-entry register and waits for load data when needed. It byte/half-extends load data, selects the final result and drives the register-file write port (wr, rd, write_data). It also provides a same-cycle bypass to decode and counts retired instructions.

---
 rtl/wb_stage_pkg.sv | 20 ++
 rtl/wb_stage_load_ext.sv | 41 ++++
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared codes for the writeback stage: result-select, load funct3 and FSM states.
package wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT_LD = 2'd1,
    COMMIT  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load extension: picks the addressed byte/half of an aligned
// word and sign- or zero-extends it. Reserved funct3 codes return the full word.
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection; the half select ignores addr_lsb[0].
  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_lsb)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type.
  always_comb begin
    ext_data = rdata;
    case (funct3)
      F3_LB:   ext_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH:   ext_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, sel_half};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single-entry holding register, waits for load data,
// drives the register-file write port plus an identical decode bypass,
// and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_reg_wr,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [1:0]        i_wb_sel,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XLEN-1:0]   i_pc_plus4,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lsb,
  input  logic              i_ld_rvalid,
  input  logic [XLEN-1:0]   i_ld_rdata,
  output logic              o_rf_wr,
  output logic [REG_AW-1:0] o_rf_rd,
  output logic [XLEN-1:0]   o_rf_wdata,
  output logic              o_fwd_valid,
  output logic [REG_AW-1:0] o_fwd_rd,
  output logic [XLEN-1:0]   o_fwd_data,
  output logic [CNT_W-1:0]  o_instret
);

  wb_state_e         state_reg, state_next;
  logic              reg_wr_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [1:0]        wb_sel_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        addr_lsb_reg;
  logic [XLEN-1:0]   result_reg;
  logic [CNT_W-1:0]  instret_reg;
  logic [XLEN-1:0]   ld_ext;
  logic              accept;
  logic              ld_done;

  assign o_ready = (state_reg == EMPTY) || (state_reg == COMMIT);
  assign accept  = i_valid && o_ready;
  // rvalid only matters while a load is outstanding.
  assign ld_done = (state_reg == WAIT_LD) && i_ld_rvalid;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3   (funct3_reg),
    .addr_lsb (addr_lsb_reg),
    .rdata    (i_ld_rdata),
    .ext_data (ld_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next state: an accept always wins, so COMMIT can refill without a bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY, COMMIT: begin
        if (accept) state_next = (i_wb_sel == WB_SEL_LOAD) ? WAIT_LD : COMMIT;
        else        state_next = EMPTY;
      end
      WAIT_LD: if (i_ld_rvalid) state_next = COMMIT;
      default: state_next = EMPTY;
    endcase
  end

  // Holding register: capture on accept, overwrite result when load data lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wr_reg   <= 1'b0;
      rd_reg       <= '0;
      wb_sel_reg   <= WB_SEL_ALU;
      funct3_reg   <= '0;
      addr_lsb_reg <= '0;
      result_reg   <= '0;
    end else if (accept) begin
      reg_wr_reg   <= i_reg_wr;
      rd_reg       <= i_rd;
      wb_sel_reg   <= i_wb_sel;
      funct3_reg   <= i_funct3;
      addr_lsb_reg <= i_addr_lsb;
      result_reg   <= (i_wb_sel == WB_SEL_PC4) ? i_pc_plus4 : i_alu_result;
    end else if (ld_done && (wb_sel_reg == WB_SEL_LOAD)) begin
      result_reg   <= ld_ext;
    end
  end

  // Retired-instruction counter: one per COMMIT cycle, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)                  instret_reg <= '0;
    else if (state_reg == COMMIT) instret_reg <= instret_reg + CNT_W'(1);
  end

  // Write port and bypass are zeroed whenever no write happens (x0 never written).
  always_comb begin
    o_rf_wr    = (state_reg == COMMIT) && reg_wr_reg && (rd_reg != '0);
    o_rf_rd    = o_rf_wr ? rd_reg : '0;
    o_rf_wdata = o_rf_wr ? result_reg : '0;
  end

  assign o_fwd_valid = o_rf_wr;
  assign o_fwd_rd    = o_rf_rd;
  assign o_fwd_data  = o_rf_wdata;
  assign o_instret   = instret_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: stimulus pushes expected register-file writes
// into a queue; a negedge monitor pops and compares every write it sees.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_reg_wr;
  logic [4:0]  i_rd;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_result;
  logic [31:0] i_pc_plus4;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lsb;
  logic        i_ld_rvalid;
  logic [31:0] i_ld_rdata;
  logic        o_rf_wr;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_wdata;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd;
  logic [31:0] o_fwd_data;
  logic [63:0] o_instret;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  logic [63:0] exp_instret = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_reg_wr(i_reg_wr), .i_rd(i_rd), .i_wb_sel(i_wb_sel),
    .i_alu_result(i_alu_result), .i_pc_plus4(i_pc_plus4),
    .i_funct3(i_funct3), .i_addr_lsb(i_addr_lsb),
    .i_ld_rvalid(i_ld_rvalid), .i_ld_rdata(i_ld_rdata),
    .o_rf_wr(o_rf_wr), .o_rf_rd(o_rf_rd), .o_rf_wdata(o_rf_wdata),
    .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data),
    .o_instret(o_instret)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    i_reg_wr = 1'b0; i_rd = 5'd31; i_wb_sel = 2'b11;
    i_alu_result = 32'h5A5A_5A5A; i_pc_plus4 = 32'hA5A5_A5A5;
    i_funct3 = 3'b111; i_addr_lsb = 2'b11;
  endtask

  // Issue one non-load op and let it retire.
  task automatic do_op(input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] exp);
    if (wr && rd != 0) exp_q.push_back({rd, exp});
    check("ready_before_op", o_ready, 1);
    i_valid = 1; i_reg_wr = wr; i_rd = rd; i_wb_sel = sel; i_alu_result = alu; i_pc_plus4 = pc4;
    tick();
    i_valid = 0; scramble();
    check("instret_in_commit", o_instret, exp_instret);
    tick();
    exp_instret++;
    check("instret_after_op", o_instret, exp_instret);
    $display("op rd=%0d sel=%0d exp=%08h instret=%0d", rd, sel, exp, o_instret);
  endtask

  // Issue one load, return data after wait_cycles, let it retire.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [31:0] rdata, input int wait_cycles, input logic [31:0] exp);
    exp_q.push_back({rd, exp});
    i_valid = 1; i_reg_wr = 1; i_rd = rd; i_wb_sel = 2'b01; i_alu_result = 32'hDEAD_BEEF;
    i_funct3 = f3; i_addr_lsb = lsb;
    tick();
    i_valid = 0; scramble();
    for (int k = 0; k < wait_cycles; k++) begin
      check("ready_wait_ld", o_ready, 0);
      tick();
    end
    i_ld_rvalid = 1; i_ld_rdata = rdata;
    check("ready_wait_ld", o_ready, 0);
    tick();
    i_ld_rvalid = 0; i_ld_rdata = 32'h0BAD_0BAD;
    check("ready_commit", o_ready, 1);
    tick();
    exp_instret++;
    check("instret_after_load", o_instret, exp_instret);
    $display("load rd=%0d f3=%0d lsb=%0d rdata=%08h exp=%08h", rd, f3, lsb, rdata, exp);
  endtask

  // Monitor: every write must match the head of the queue; idle outputs must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_rf_wr) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=x%0d=%08h required=no write", o_rf_rd, o_rf_wdata);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("rf_write", {o_rf_rd, o_rf_wdata}, e);
          check("fwd_write", {o_fwd_valid, o_fwd_rd, o_fwd_data}, {1'b1, e});
          $display("write x%0d=%08h", o_rf_rd, o_rf_wdata);
        end
      end else begin
        check("idle_zero", {o_rf_rd, o_rf_wdata, o_fwd_valid, o_fwd_rd, o_fwd_data}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; i_valid = 0; i_ld_rvalid = 0; i_ld_rdata = 0; scramble();
    tick(); tick();
    check("reset_ready", o_ready, 1);
    check("reset_instret", o_instret, 0);
    check("reset_rf_wr", o_rf_wr, 0);
    rst_n = 1;
    mon_en = 1;

    do_op(1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0000_1234);

    do_load(5'd7, 3'b000, 2'd2, 32'h1280_FF00, 3, 32'hFFFF_FF80);
    do_load(5'd7, 3'b100, 2'd2, 32'h1280_FF00, 3, 32'h0000_0080);
    do_load(5'd8, 3'b000, 2'd1, 32'h1280_FF00, 0, 32'hFFFF_FFFF);
    do_load(5'd8, 3'b001, 2'd2, 32'h8001_1234, 1, 32'hFFFF_8001);
    do_load(5'd8, 3'b101, 2'd3, 32'h8001_1234, 1, 32'h0000_8001);
    do_load(5'd8, 3'b010, 2'd2, 32'h8001_1234, 2, 32'h8001_1234);
    do_load(5'd8, 3'b011, 2'd1, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

    // Back-to-back: three accepts on consecutive edges.
    exp_q.push_back({5'd1, 32'h0000_000A});
    exp_q.push_back({5'd2, 32'h0000_0104});
    i_valid = 1; i_reg_wr = 1; i_rd = 5'd1; i_wb_sel = 2'b00; i_alu_result = 32'hA;
    check("b2b_ready0", o_ready, 1);
    tick();
    i_rd = 5'd0; i_alu_result = 32'hB;
    check("b2b_ready1", o_ready, 1);
    tick();
    i_rd = 5'd2; i_wb_sel = 2'b10; i_alu_result = 32'hFFFF_0000; i_pc_plus4 = 32'h104;
    check("b2b_ready2", o_ready, 1);
    tick();
    i_valid = 0; scramble();
    tick();
    exp_instret += 3;
    check("b2b_instret", o_instret, exp_instret);
    $display("back-to-back instret=%0d", o_instret);

    // Stray rvalid while EMPTY.
    i_ld_rvalid = 1; i_ld_rdata = 32'h1111_2222;
    tick(); tick();
    i_ld_rvalid = 0;
    check("stray_ready", o_ready, 1);
    check("stray_instret", o_instret, exp_instret);
    $display("stray rvalid instret=%0d", o_instret);

    // Reset while a load to x9 is outstanding.
    i_valid = 1; i_reg_wr = 1; i_rd = 5'd9; i_wb_sel = 2'b01; i_funct3 = 3'b010;
    tick();
    i_valid = 0; scramble();
    check("pre_reset_ready", o_ready, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    exp_instret = 0;
    check("mid_reset_ready", o_ready, 1);
    check("mid_reset_instret", o_instret, 0);
    check("mid_reset_rf_wr", o_rf_wr, 0);
    i_ld_rvalid = 1; i_ld_rdata = 32'h9999_9999;
    tick();
    i_ld_rvalid = 0;
    check("post_reset_ready", o_ready, 1);
    $display("reset during load instret=%0d", o_instret);

    do_op(1, 5'd3, 2'b11, 32'h0000_0777, 32'h0000_0888, 32'h0000_0777);
    do_op(0, 5'd4, 2'b00, 32'h0000_0999, 32'h0, 32'h0);

    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
